// File: rtl/sb_pkg.sv
// Shared constants and types for the posted-write store buffer.
package sb_pkg;

    // Default number of buffered stores (must be a power of two, at least 2)
    localparam int SB_DEPTH = 4;

    // Default address and data widths of the MIPS datapath
    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    // Pointer width for the default depth
    localparam int PTR_W = $clog2(SB_DEPTH);

    // Lowest address bit that takes part in word matching (word stores only)
    localparam int WORD_LSB = 2;

    // One buffered store at the default widths
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search across the live store buffer entries.
// Entries are visited from oldest (head) to youngest, so the last hit wins.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic [DEPTH-1:0][AW-WORD_LSB-1:0] entry_word,
    input  logic [DEPTH-1:0][DW-1:0]          entry_data,
    input  logic [$clog2(DEPTH)-1:0]          head,
    input  logic [$clog2(DEPTH):0]            count,
    input  logic [AW-WORD_LSB-1:0]            lookup_word,
    output logic                              hit,
    output logic [DW-1:0]                     data
);

    localparam int PB = $clog2(DEPTH);

    // Walk offsets 0..DEPTH-1 from head; only offsets below count are live
    always_comb begin
        logic [PB-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PB'(k);
            if (((PB+1)'(k) < count) && (entry_word[idx] == lookup_word)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the single-cycle MIPS datapath and a
// data RAM with a valid/ready write port. Stores are queued in a circular
// FIFO and drained in order; loads are forwarded from the youngest matching
// buffered store or taken from the RAM read port.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [AW-1:0] ALuOut,
    input  logic [DW-1:0] WriteData,
    output logic [DW-1:0] RD,
    output logic          stall,
    output logic          sb_empty,
    output logic          mem_wvalid,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int WAW      = AW - WORD_LSB;
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [DEPTH-1:0][AW-1:0]  addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0]  data_q, data_d;
    logic [PTR_BITS-1:0]       head_q, head_d;
    logic [PTR_BITS-1:0]       tail_q, tail_d;
    logic [PTR_BITS:0]         count_q, count_d;

    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;

    logic [DEPTH-1:0][WAW-1:0] addr_word;
    logic                      fwd_hit;
    logic [DW-1:0]             fwd_data;

    // Occupancy flags and handshake qualifiers, all from registered count
    // so that stall never depends on mem_wready
    always_comb begin
        full  = (count_q == FULL_COUNT);
        empty = (count_q == '0);
        push  = MemWrite && !full;
        pop   = !empty && mem_wready;
    end

    // Next-state for the pointers and count
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + PTR_BITS'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_BITS'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
            2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards every pending store
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the accepted store into the tail slot
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (push) begin
            addr_d[tail_q] = ALuOut;
            data_d[tail_q] = WriteData;
        end
    end

    // Entry storage carries no reset; validity comes from head and count
    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Strip the byte offset so the search compares whole words
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_word[i] = addr_q[i][AW-1:WORD_LSB];
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd_match (
        .entry_word  (addr_word),
        .entry_data  (data_q),
        .head        (head_q),
        .count       (count_q),
        .lookup_word (ALuOut[AW-1:WORD_LSB]),
        .hit         (fwd_hit),
        .data        (fwd_data)
    );

    // Core-facing outputs and the RAM write/read ports
    always_comb begin
        stall      = MemWrite && full;
        sb_empty   = empty;
        mem_wvalid = !empty;
        mem_waddr  = addr_q[head_q];
        mem_wdata  = data_q[head_q];
        mem_raddr  = ALuOut;
        RD         = (MemRead && fwd_hit) ? fwd_data : mem_rdata;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer plus hand-written
// sequences for wrap-around draining and asynchronous reset mid-drain.
module tb_store_buffer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] alu_out;
    logic [DW-1:0] write_data;
    logic [DW-1:0] rd;
    logic          stall;
    logic          sb_empty;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    int checks_total  = 0;
    int checks_passed = 0;

    logic        rec_en = 1'b0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    typedef struct {
        logic        wr;
        logic        rd_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wready;
        logic [31:0] rdata;
        logic        exp_stall;
        logic        exp_wvalid;
        logic [31:0] exp_rd;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .CLK        (clk),
        .rst        (rst),
        .MemWrite   (mem_write),
        .MemRead    (mem_read),
        .ALuOut     (alu_out),
        .WriteData  (write_data),
        .RD         (rd),
        .stall      (stall),
        .sb_empty   (sb_empty),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
    );

    // Record every write the RAM accepts, sampled mid-cycle
    always @(negedge clk) begin
        if (rec_en && rst && mem_wvalid && mem_wready) begin
            got_addr.push_back(mem_waddr);
            got_data.push_back(mem_wdata);
        end
    end

    function automatic vec_t mk(input logic wr, input logic rd_en,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic wready, input logic [31:0] rdata,
                                input logic es, input logic ev,
                                input logic [31:0] erd, input logic [31:0] ewa,
                                input logic [31:0] ewd);
        vec_t v;
        v.wr = wr; v.rd_en = rd_en; v.addr = addr; v.wdata = wdata;
        v.wready = wready; v.rdata = rdata; v.exp_stall = es;
        v.exp_wvalid = ev; v.exp_rd = erd; v.exp_waddr = ewa; v.exp_wdata = ewd;
        return v;
    endfunction

    task automatic applyStimulus(input logic wr, input logic rd_en,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic wready, input logic [31:0] rdata);
        mem_write  = wr;
        mem_read   = rd_en;
        alu_out    = addr;
        write_data = wdata;
        mem_wready = wready;
        mem_rdata  = rdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        int model_count;
        logic wr_ready;
        logic exp_stall;
        logic m_push;
        logic m_pop;

        // Fields: wr, rd_en, addr, wdata, wready, rdata | stall, wvalid, RD, waddr, wdata
        vecs[0]  = mk(1, 0, 32'h10, 32'hAAAA5555, 0, 32'h1111, 0, 0, 32'h1111, 32'h0,  32'h0);
        vecs[1]  = mk(0, 0, 32'h00, 32'h0,        0, 32'h2222, 0, 1, 32'h2222, 32'h10, 32'hAAAA5555);
        vecs[2]  = mk(0, 1, 32'h10, 32'h0,        1, 32'hDEAD, 0, 1, 32'hAAAA5555, 32'h10, 32'hAAAA5555);
        vecs[3]  = mk(0, 1, 32'h10, 32'h0,        0, 32'hDEAD, 0, 0, 32'hDEAD, 32'h0,  32'h0);
        vecs[4]  = mk(1, 0, 32'h00, 32'hA0,       0, 32'h5,    0, 0, 32'h5,    32'h0,  32'h0);
        vecs[5]  = mk(1, 0, 32'h04, 32'hA1,       0, 32'h5,    0, 1, 32'h5,    32'h0,  32'hA0);
        vecs[6]  = mk(1, 0, 32'h08, 32'hA2,       0, 32'h5,    0, 1, 32'h5,    32'h0,  32'hA0);
        vecs[7]  = mk(1, 0, 32'h0C, 32'hA3,       0, 32'h5,    0, 1, 32'h5,    32'h0,  32'hA0);
        vecs[8]  = mk(1, 0, 32'h20, 32'hB0,       0, 32'h5,    1, 1, 32'h5,    32'h0,  32'hA0);
        vecs[9]  = mk(1, 0, 32'h20, 32'hB0,       1, 32'h5,    1, 1, 32'h5,    32'h0,  32'hA0);
        vecs[10] = mk(1, 0, 32'h20, 32'hB0,       0, 32'h5,    0, 1, 32'h5,    32'h4,  32'hA1);
        vecs[11] = mk(0, 1, 32'h20, 32'h0,        0, 32'hDEAD, 0, 1, 32'hB0,   32'h4,  32'hA1);
        vecs[12] = mk(0, 1, 32'h22, 32'h0,        0, 32'hDEAD, 0, 1, 32'hB0,   32'h4,  32'hA1);
        vecs[13] = mk(0, 1, 32'h24, 32'h0,        0, 32'hDEAD, 0, 1, 32'hDEAD, 32'h4,  32'hA1);
        vecs[14] = mk(1, 0, 32'h40, 32'h1,        1, 32'hDEAD, 1, 1, 32'hDEAD, 32'h4,  32'hA1);
        vecs[15] = mk(1, 0, 32'h40, 32'h1,        0, 32'hDEAD, 0, 1, 32'hDEAD, 32'h8,  32'hA2);
        vecs[16] = mk(1, 0, 32'h40, 32'h2,        1, 32'hDEAD, 1, 1, 32'hDEAD, 32'h8,  32'hA2);
        vecs[17] = mk(1, 0, 32'h40, 32'h2,        0, 32'hDEAD, 0, 1, 32'hDEAD, 32'hC,  32'hA3);
        vecs[18] = mk(0, 1, 32'h40, 32'h0,        0, 32'hDEAD, 0, 1, 32'h2,    32'hC,  32'hA3);
        vecs[19] = mk(1, 1, 32'h40, 32'h3,        1, 32'hDEAD, 1, 1, 32'h2,    32'hC,  32'hA3);
        vecs[20] = mk(1, 1, 32'h40, 32'h3,        0, 32'hDEAD, 0, 1, 32'h2,    32'h20, 32'hB0);
        vecs[21] = mk(0, 1, 32'h40, 32'h0,        0, 32'hDEAD, 0, 1, 32'h3,    32'h20, 32'hB0);
        vecs[22] = mk(0, 0, 32'h40, 32'h0,        0, 32'h77,   0, 1, 32'h77,   32'h20, 32'hB0);
        vecs[23] = mk(0, 1, 32'h08, 32'h0,        0, 32'h99,   0, 1, 32'h99,   32'h20, 32'hB0);

        // Reset held with a store request present
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h1, 1'b1, 32'h1234);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset stall", 32'(stall), 32'h0);
        checkOutput("reset wvalid", 32'(mem_wvalid), 32'h0);
        checkOutput("reset empty", 32'(sb_empty), 32'h1);
        checkOutput("reset RD", rd, 32'h1234);
        checkOutput("reset raddr", mem_raddr, 32'h10);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Table-driven vectors: outputs checked before the clock edge
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].rd_en, vecs[i].addr, vecs[i].wdata,
                          vecs[i].wready, vecs[i].rdata);
            #1;
            checkOutput($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            checkOutput($sformatf("v%0d wvalid", i), 32'(mem_wvalid), 32'(vecs[i].exp_wvalid));
            checkOutput($sformatf("v%0d empty", i), 32'(sb_empty), 32'(!vecs[i].exp_wvalid));
            checkOutput($sformatf("v%0d RD", i), rd, vecs[i].exp_rd);
            if (vecs[i].exp_wvalid) begin
                checkOutput($sformatf("v%0d waddr", i), mem_waddr, vecs[i].exp_waddr);
                checkOutput($sformatf("v%0d wdata", i), mem_wdata, vecs[i].exp_wdata);
            end
            @(posedge clk);
            #1;
        end

        // Wrap-around: 10 stores with wready toggling, occupancy modelled here
        doReset();
        got_addr.delete();
        got_data.delete();
        rec_en = 1'b1;
        idx = 0;
        cyc = 0;
        model_count = 0;
        while (idx < 10 && cyc < 100) begin
            wr_ready = (cyc % 2 == 0);
            applyStimulus(1'b1, 1'b0, 32'(4 * idx), 32'h100 + 32'(idx), wr_ready, 32'h0);
            #1;
            exp_stall = (model_count == DEPTH);
            checkOutput($sformatf("wrap c%0d stall", cyc), 32'(stall), 32'(exp_stall));
            m_push = !exp_stall;
            m_pop  = (model_count > 0) && wr_ready;
            model_count = model_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_push) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("wrap stores accepted", 32'(idx), 32'd10);

        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        cyc = 0;
        while (!sb_empty && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("wrap drained", 32'(sb_empty), 32'h1);
        @(posedge clk);
        #1;
        rec_en = 1'b0;
        checkOutput("wrap RAM write count", 32'(got_addr.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_addr.size()) begin
                checkOutput($sformatf("wrap w%0d addr", i), got_addr[i], 32'(4 * i));
                checkOutput($sformatf("wrap w%0d data", i), got_data[i], 32'h100 + 32'(i));
            end
        end

        // Reset asserted mid-drain with three pending stores
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'h50 + 32'(i), 1'b0, 32'h0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("pre-reset wvalid", 32'(mem_wvalid), 32'h1);
        checkOutput("pre-reset waddr", mem_waddr, 32'h200);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async reset wvalid", 32'(mem_wvalid), 32'h0);
        checkOutput("async reset empty", 32'(sb_empty), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("post-reset empty", 32'(sb_empty), 32'h1);
        checkOutput("post-reset wvalid", 32'(mem_wvalid), 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h5, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("post-reset store waddr", mem_waddr, 32'h300);
        checkOutput("post-reset store wdata", mem_wdata, 32'h5);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write store buffer between the single-cycle MIPS datapath and a data RAM whose write port can be slower than the core. It accepts stores from the datapath (`ALuOut` as address, `WriteData` as data) into a DEPTH-entry FIFO and drains them to memory over a valid/ready handshake. Loads are returned to the datapath's `RD` input, forwarded from the youngest matching buffered store, otherwise taken from the RAM read port. `stall` holds the PC while the buffer cannot accept a store.

## Interface
- DEPTH, 4: buffer entries (power of two, ≥2)
- AW, 32: address width
- DW, 32: data width
- CLK  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- MemWrite  in  1  store request from control unit
- MemRead  in  1  load request from control unit
- ALuOut  in  AW  effective address from datapath
- WriteData  in  DW  store data from datapath
- RD  out  DW  load data to datapath (combinational)
- stall  out  1  core must hold PC/state this cycle
- sb_empty  out  1  no pending stores
- mem_wvalid  out  1  head entry valid toward RAM
- mem_wready  in  1  RAM accepts write this cycle
- mem_waddr  out  AW  head entry address
- mem_wdata  out  DW  head entry data
- mem_raddr  out  AW  RAM read address (= ALuOut)
- mem_rdata  in  DW  RAM read data (combinational RAM)

## Operation
- Storage: circular FIFO of {addr, data}, registered head pointer, tail pointer, and count (0..DEPTH). full = (count==DEPTH), empty = (count==0).
- Enqueue: MemWrite && !full → write {ALuOut, WriteData} at tail, tail+1 mod DEPTH.
- Stall: stall = MemWrite && full. It depends only on registered count, with no combinational path from mem_wready. A stalled store is not enqueued. The core re-presents it next cycle.
- Drain: mem_wvalid = !empty. mem_waddr/mem_wdata = head entry. mem_wvalid && mem_wready → head+1, entry retired.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. When full, enqueue is still refused that cycle (stall already asserted).
- Count update: +1 on enqueue only, −1 on pop only, unchanged on both or neither.
- Forwarding: the word address compares ALuOut[AW-1:2] with each valid entry's addr[AW-1:2]. The youngest valid match (closest to tail) supplies RD. With no match, RD = mem_rdata. The lookup is active whenever MemRead=1. With MemRead=0, RD = mem_rdata.
- An entry popped in the current cycle is still valid for forwarding in that cycle.
- MemRead && MemWrite together: the store is enqueued normally, and RD follows the lookup against pre-enqueue contents.
- Pointer wrap-around: modulo DEPTH. A mid-FIFO entry is valid iff its offset from head < count.
- Byte lanes are not supported: word stores only, addr[1:0] passed through on mem_waddr unmodified.

## Timing
- Reset (rst=0, async): count=0, head=tail=0, mem_wvalid=0, stall=0, sb_empty=1. RD = mem_rdata. Entry storage is not reset. Reset mid-drain discards all pending stores; mem_wvalid falls immediately.
- Enqueue latency: a store presented in cycle N is forwardable and presented on mem_wvalid from cycle N+1.
- Throughput: 1 store/cycle sustained when mem_wready=1 every cycle and count<DEPTH.
- RD, stall, mem_raddr: combinational from inputs and registered state, valid within the same cycle.
- mem_waddr/mem_wdata stay stable while mem_wvalid=1 and mem_wready=0.

## Structure
- Package `sb_pkg`: SB_DEPTH default, PTR_W = $clog2(DEPTH), entry typedef {addr, data}, WORD_LSB=2 constant.
- Sub-module `sb_fwd_match`: combinational youngest-match priority search over DEPTH entries. Inputs are the entry array, head, count, and lookup address. Outputs are hit and data.
- Top `store_buffer`: pointers, count, storage registers, handshake, stall, and RD mux.

## Test plan
- Reset: hold rst=0 with MemWrite=1 → stall=0, mem_wvalid=0, sb_empty=1. Release, store 0x10←0xAAAA5555 → mem_wvalid=1 next cycle with waddr=0x10, wdata=0xAAAA5555.
- Fill/stall: mem_wready=0, store to 0x0,0x4,0x8,0xC → count=4. A fifth store to 0x20 → stall=1 and not enqueued. Raise wready for one cycle → stall=0 the following cycle, and 0x20 is enqueued on retry.
- Forwarding: with wready=0, store 0x40←1, then 0x40←2, then load 0x40 (mem_rdata=0xDEAD) → RD=2. Load 0x44 → RD=0xDEAD.
- Pop-and-forward: a single entry 0x80←7, with wready=1 and a load of 0x80 in the same cycle → RD=7 and the entry retires. Next cycle the load returns mem_rdata.
- Wrap-around: 10 stores at addresses 4·i, with wready toggling 1,0,1,0… → RAM receives all 10 in order with no loss or duplication, and count never exceeds 4.
- Reset mid-drain: 3 pending entries, assert rst=0 asynchronously mid-cycle → mem_wvalid=0 immediately, and sb_empty=1 after release.
